// File: rtl/pipe_stage_chain.sv
// pipe_stage_chain: DEPTH-stage pipeline register chain with stall, flush, bubbles, hazard taps
module pipe_stage_chain #(
  parameter int DEPTH  = 1,
  parameter int DATA_W = 64,
  parameter int CTRL_W = 2,
  parameter int RD_W   = 5
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   valid_i,
  input  logic [CTRL_W-1:0]      ctrl_i,
  input  logic [RD_W-1:0]        rd_i,
  input  logic [DATA_W-1:0]      data_i,
  input  logic [DEPTH-1:0]       stall_i,
  input  logic [DEPTH-1:0]       flush_i,
  output logic                   in_ready_o,
  output logic                   valid_o,
  output logic [CTRL_W-1:0]      ctrl_o,
  output logic [RD_W-1:0]        rd_o,
  output logic [DATA_W-1:0]      data_o,
  output logic [DEPTH-1:0]       tap_valid_o,
  output logic [DEPTH*RD_W-1:0]  tap_rd_o,
  output logic [15:0]            bubble_cnt_o
);
  logic [DEPTH-1:0]              valid_q, valid_d, hold, up_hold;
  logic [DEPTH-1:0][CTRL_W-1:0]  ctrl_q, ctrl_d;
  logic [DEPTH-1:0][RD_W-1:0]    rd_q, rd_d;
  logic [DEPTH-1:0][DATA_W-1:0]  data_q, data_d;
  logic [DEPTH:0]                valid_x;
  logic [DEPTH:0][CTRL_W-1:0]    ctrl_x;
  logic [DEPTH:0][RD_W-1:0]      rd_x;
  logic [DEPTH:0][DATA_W-1:0]    data_x;
  logic [15:0]                   bubble_q, bubble_d;
  // entry k of the *_x vectors is the source feeding stage k
  assign valid_x = {valid_q, valid_i};
  assign ctrl_x  = {ctrl_q, ctrl_i};
  assign rd_x    = {rd_q, rd_i};
  assign data_x  = {data_q, data_i};
  always_comb begin
    hold = stall_i;
    for (int k = DEPTH - 2; k >= 0; k--) hold[k] = hold[k+1] | stall_i[k];
    up_hold = hold << 1;
  end
  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      valid_d[k] = flush_i[k] ? 1'b0 : hold[k] ? valid_q[k] : up_hold[k] ? 1'b0 : valid_x[k];
      ctrl_d[k]  = valid_d[k] ? (hold[k] ? ctrl_q[k] : ctrl_x[k]) : '0;
      rd_d[k]    = (flush_i[k] || hold[k] || up_hold[k]) ? rd_q[k] : rd_x[k];
      data_d[k]  = (flush_i[k] || hold[k] || up_hold[k]) ? data_q[k] : data_x[k];
    end
    bubble_d = bubble_q + 16'(!valid_q[DEPTH-1] && bubble_q != '1);
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q  <= '0;
      ctrl_q   <= '0;
      rd_q     <= '0;
      data_q   <= '0;
      bubble_q <= '0;
    end else begin
      valid_q  <= valid_d;
      ctrl_q   <= ctrl_d;
      rd_q     <= rd_d;
      data_q   <= data_d;
      bubble_q <= bubble_d;
    end
  end
  assign in_ready_o   = ~hold[0];
  assign valid_o      = valid_q[DEPTH-1];
  assign ctrl_o       = ctrl_q[DEPTH-1];
  assign rd_o         = rd_q[DEPTH-1];
  assign data_o       = data_q[DEPTH-1];
  assign tap_valid_o  = valid_q;
  assign tap_rd_o     = rd_q;
  assign bubble_cnt_o = bubble_q;
endmodule
